// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: sequencer states, address constants and the
// jump-target concatenator used wherever a J/JAL target is formed.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int WORD_BYTES      = 4;
  localparam int JUMP_REGION_MSB = 31;
  localparam int JUMP_REGION_LSB = 28;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'h8000_0180;

  // J/JAL stay inside the 256 MB region of the delay-slot instruction.
  function automatic logic [31:0] jump_concat(input logic [31:0] pc4,
                                              input logic [25:0] index);
    return {pc4[JUMP_REGION_MSB:JUMP_REGION_LSB], index, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_target.sv
// Combinational redirect selection: priority mux jump_reg > jump > branch,
// plus misaligned jump-register detection.
import mips_pkg::*;

module next_pc_target (
  input  logic [31:0] redir_pc4,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_addr,
  output logic        redirect,
  output logic [31:0] target,
  output logic        misaligned
);

  always_comb begin
    redirect   = 1'b0;
    misaligned = 1'b0;
    target     = redir_pc4;
    if (jump_reg) begin
      redirect   = 1'b1;
      misaligned = |jump_reg_addr[1:0];
      target     = misaligned ? EXC_VECTOR : jump_reg_addr;
    end else if (jump) begin
      redirect = 1'b1;
      target   = jump_concat(redir_pc4, jump_index);
    end else if (branch_taken) begin
      redirect = 1'b1;
      target   = redir_pc4 + (branch_offset << 2);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: holds the PC, issues fetch requests and parks a
// redirect in a pending register until the current fetch is accepted.
import mips_pkg::*;

module pc_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        fetch_ack,
  input  logic [31:0] redir_pc4,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_addr,
  output logic [31:0] pc,
  output logic        fetch_req,
  output logic [31:0] pc_plus4,
  output logic        redirect_taken,
  output logic        addr_error,
  output state_e      state_dbg
);

  // Handshake: fetch_req is valid, fetch_ack is ready; a fetch completes on an
  // edge with both high and stall low, and pc is frozen while fetch_req waits.
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        redir_q, redir_d;
  logic        err_q, err_d;

  logic        redirect;
  logic        misaligned;
  logic [31:0] target;
  logic        advance;

  next_pc_target u_target (
    .redir_pc4     (redir_pc4),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .jump_reg_addr (jump_reg_addr),
    .redirect      (redirect),
    .target        (target),
    .misaligned    (misaligned)
  );

  assign advance = fetch_ack & ~stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    redir_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        err_d = redirect & misaligned;
        if (redirect && advance) begin
          pc_d    = target;
          redir_d = 1'b1;
        end else if (redirect) begin
          pend_d  = target;
          state_d = HOLD;
        end else if (advance) begin
          pc_d = pc_q + 32'(WORD_BYTES);
        end
      end
      HOLD: begin
        err_d = redirect & misaligned;
        // A redirect resolving in the releasing cycle is the newest one and wins.
        if (advance) begin
          pc_d    = redirect ? target : pend_q;
          pend_d  = '0;
          redir_d = 1'b1;
          state_d = RUN;
        end else if (redirect) begin
          pend_d = target;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      pend_q  <= '0;
      redir_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      redir_q <= redir_d;
      err_q   <= err_d;
    end
  end

  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'(WORD_BYTES);
  assign fetch_req      = (state_q != BOOT);
  assign redirect_taken = redir_q;
  assign addr_error     = err_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic checked
// against a pending-target reference model.
import mips_pkg::*;

module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, fetch_ack;
  logic [31:0] redir_pc4, branch_offset, jump_reg_addr;
  logic        branch_taken, jump, jump_reg;
  logic [25:0] jump_index;
  logic [31:0] pc, pc_plus4;
  logic        fetch_req, redirect_taken, addr_error;
  state_e      state_dbg;

  int n_checks = 0;
  int n_fails  = 0;

  // reference model
  logic [31:0] exp_q[$];
  logic [31:0] m_pc, m_pend;
  bit          m_boot, m_pend_v, m_redir, m_err;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .fetch_ack(fetch_ack),
    .redir_pc4(redir_pc4), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
    .jump_reg(jump_reg), .jump_reg_addr(jump_reg_addr),
    .pc(pc), .fetch_req(fetch_req), .pc_plus4(pc_plus4),
    .redirect_taken(redirect_taken), .addr_error(addr_error),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; fetch_ack = 0; redir_pc4 = 0; branch_taken = 0; branch_offset = 0;
    jump = 0; jump_index = 0; jump_reg = 0; jump_reg_addr = 0;
  endtask

  function automatic logic [31:0] model_target(output bit any, output bit bad);
    any = jump_reg | jump | branch_taken;
    bad = jump_reg && (jump_reg_addr % 4 != 0);
    if (jump_reg) return bad ? 32'h8000_0180 : jump_reg_addr;
    if (jump) return (redir_pc4 & 32'hF000_0000) | (32'(jump_index) * 4);
    return redir_pc4 + branch_offset * 4;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pc = 32'hBFC0_0000; m_pend = 0;
    m_boot = 1; m_pend_v = 0; m_redir = 0; m_err = 0;
    exp_q.push_back(m_pc);
  endtask

  task automatic model_step();
    bit any, bad;
    logic [31:0] tgt;
    tgt = model_target(any, bad);
    m_redir = 0; m_err = 0;
    if (m_boot) begin
      m_boot = 0;
    end else begin
      m_err = any && bad;
      if (fetch_ack && !stall) begin
        if (any || m_pend_v) begin
          m_pc    = any ? tgt : m_pend;
          m_redir = 1;
        end else begin
          m_pc = m_pc + 4;
        end
        m_pend_v = 0;
      end else if (any) begin
        m_pend   = tgt;
        m_pend_v = 1;
      end
    end
    exp_q.push_back(m_pc);
  endtask

  task automatic check_outputs();
    logic [31:0] e_pc;
    logic [1:0]  e_state;
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 32'd1, 32'd0);
      return;
    end
    e_pc    = exp_q.pop_front();
    e_state = m_boot ? 2'd0 : (m_pend_v ? 2'd2 : 2'd1);
    check_eq("pc", pc, e_pc);
    check_eq("pc_plus4", pc_plus4, e_pc + 32'd4);
    check_eq("fetch_req", 32'(fetch_req), 32'(!m_boot));
    check_eq("redirect_taken", 32'(redirect_taken), 32'(m_redir));
    check_eq("addr_error", 32'(addr_error), 32'(m_err));
    check_eq("state", 32'(state_dbg), 32'(e_state));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    check_outputs();
    rst = 0;

    // reset then sequential fetch
    fetch_ack = 1;
    tick();
    check_eq("boot_exit_pc", pc, 32'hBFC0_0000);
    tick();
    check_eq("seq_pc1", pc, 32'hBFC0_0004);
    tick();
    check_eq("seq_pc2", pc, 32'hBFC0_0008);

    // jump accepted together with fetch_ack
    redir_pc4 = 32'h0040_0010; jump = 1; jump_index = 26'h010_0040;
    tick();
    check_eq("jump_pc", pc, 32'h0040_0100);
    check_eq("jump_pulse", 32'(redirect_taken), 32'd1);
    jump = 0;
    tick();
    check_eq("jump_pulse_end", 32'(redirect_taken), 32'd0);

    // branch during a 3-cycle stall
    stall = 1; redir_pc4 = 32'h0000_1000; branch_offset = 32'hFFFF_FFFC; branch_taken = 1;
    tick();
    branch_taken = 0;
    check_eq("branch_hold_state", 32'(state_dbg), 32'(HOLD));
    tick();
    tick();
    check_eq("branch_hold_pc", pc, 32'h0040_0104);
    stall = 0;
    tick();
    check_eq("branch_pc", pc, 32'h0000_0FF0);
    tick();
    check_eq("branch_next_pc", pc, 32'h0000_0FF4);

    // simultaneous redirects
    jump_reg = 1; jump_reg_addr = 32'h2000; jump = 1; jump_index = 26'h3; branch_taken = 1;
    tick();
    check_eq("prio_pc", pc, 32'h0000_2000);
    jump = 0; branch_taken = 0;

    // misaligned jump register
    jump_reg_addr = 32'h2002;
    tick();
    check_eq("misalign_pc", pc, 32'h8000_0180);
    check_eq("addr_error_hi", 32'(addr_error), 32'd1);
    jump_reg = 0;
    tick();
    check_eq("addr_error_lo", 32'(addr_error), 32'd0);

    // wrap-around
    jump_reg = 1; jump_reg_addr = 32'hFFFF_FFFC;
    tick();
    jump_reg = 0;
    tick();
    check_eq("wrap_pc", pc, 32'h0000_0000);

    // reset in the middle of HOLD
    stall = 1; jump = 1; redir_pc4 = 32'h1000; jump_index = 26'h5;
    tick();
    check_eq("pre_rst_state", 32'(state_dbg), 32'(HOLD));
    #2 rst = 1;
    #1;
    check_eq("async_rst_pc", pc, 32'hBFC0_0000);
    check_eq("async_rst_req", 32'(fetch_req), 32'd0);
    check_eq("async_rst_state", 32'(state_dbg), 32'(BOOT));
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check_outputs();
    rst = 0;
    fetch_ack = 1;
    tick();
    tick();
    check_eq("post_rst_pc", pc, 32'hBFC0_0004);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      fetch_ack     = ($urandom_range(0, 3) != 0);
      stall         = ($urandom_range(0, 3) == 0);
      redir_pc4     = $urandom & 32'hFFFF_FFFC;
      branch_offset = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32;
      branch_taken  = ($urandom_range(0, 7) == 0);
      jump          = ($urandom_range(0, 9) == 0);
      jump_index    = 26'($urandom);
      jump_reg      = ($urandom_range(0, 9) == 0);
      jump_reg_addr = $urandom_range(0, 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      if (i == 200) redir_pc4 = 32'hFFFF_FFF8;
      tick();
    end
    clear_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the MIPS CPU fetch stage. It holds the architectural PC and drives instruction fetch through a request/acknowledge handshake. It chooses each next PC from sequential (PC+4), branch, jump (PC[31:28] concatenated with index<<2), jump-register and exception targets. A redirect that arrives during a stall or an outstanding fetch is captured and applied exactly once.

## Interface
- RESET_VECTOR, 32'hBFC0_0000, PC loaded on reset
- EXC_VECTOR, 32'h8000_0180, target on misaligned jump-register
- clk  input  1  system clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- stall  input  1  downstream hazard stall; freezes PC advance
- fetch_ack  input  1  instruction memory accepted current fetch_req
- redir_pc4  input  32  PC+4 of the resolving branch/jump instruction
- branch_taken  input  1  conditional branch resolved taken
- branch_offset  input  32  sign-extended word offset, not yet shifted
- jump  input  1  J/JAL resolved
- jump_index  input  26  instruction index field
- jump_reg  input  1  JR/JALR resolved
- jump_reg_addr  input  32  register target
- pc  output  32  current fetch address
- fetch_req  output  1  fetch request valid
- pc_plus4  output  32  pc + 4, combinational
- redirect_taken  output  1  one-cycle pulse when a redirect target loads into pc
- addr_error  output  1  one-cycle pulse when a misaligned jump_reg is detected

## Operation
- Reset (async): pc=RESET_VECTOR, state=BOOT, fetch_req=0, redirect_taken=0, addr_error=0, pending cleared.
- Target computation, modulo 2^32:
  - branch: redir_pc4 + (branch_offset<<2)
  - jump: {redir_pc4[31:28], jump_index, 2'b00}
  - jump_reg: jump_reg_addr
- Target priority when several resolve in one cycle: jump_reg > jump > branch_taken.
- jump_reg with jump_reg_addr[1:0]!=0: target becomes EXC_VECTOR, addr_error pulses in the cycle after detection.
- States:
  - BOOT: first cycle after rst deasserts; goes to RUN; fetch_req=0.
  - RUN: fetch_req=1. Transitions, first match wins:
    - Redirect and fetch_ack and !stall: pc<=target, redirect_taken pulse; stay in RUN.
    - Redirect otherwise: target captured into pending; go to HOLD.
    - fetch_ack and !stall: pc<=pc+4.
    - Else: stay in RUN, pc held.
  - HOLD: pending target valid; fetch_req=1 with the current pc.
    - On fetch_ack and !stall: pc<=pending, redirect_taken pulse, pending cleared; go to RUN.
    - A new redirect in HOLD overwrites pending (last resolved wins).
- fetch_req/pc stability: once fetch_req=1, pc must not change until fetch_ack, except on reset.
- Wrap-around: pc=32'hFFFF_FFFC with a sequential advance gives 32'h0000_0000. No error is flagged.

## Timing
- Sequential advance: pc updates on the clock edge where fetch_ack=1 and stall=0. Throughput is one fetch per cycle.
- Redirect latency: 1 cycle from resolve to the new pc when fetch_ack=1 and stall=0 in the same cycle. Otherwise the new pc loads on the first edge with fetch_ack=1 and stall=0.
- redirect_taken and addr_error are registered and high for exactly one cycle.
- pc_plus4 is combinational from pc, zero added latency.
- rst asserted mid-HOLD: pending is discarded and pc=RESET_VECTOR immediately (asynchronous).

## Structure
- Shared package mips_pkg:
  - state enum {BOOT, RUN, HOLD}
  - localparams WORD_BYTES=4 and JUMP_REGION_MSB=31/LSB=28
- Sub-module: next_pc_target, combinational. It holds the priority mux and arithmetic and reuses the existing jump concatenator for the jump target.
- pc_sequencer contains only the state register, pc register, pending register and pulse flops.

## Test plan
- Reset and sequential fetch:
  - Stimulus: release rst, then hold fetch_ack=1.
  - Required: pc=BFC00000, then BFC00004 and BFC00008 on successive edges; fetch_req=0 only in BOOT.
- Jump during fetch_ack:
  - Stimulus: redir_pc4=0x00400010, jump=1, jump_index=0x0100040, fetch_ack=1.
  - Required: next pc=0x00400100 with a one-cycle redirect_taken pulse.
- Branch during stall:
  - Stimulus: redir_pc4=0x1000, branch_offset=-4, stall=1 for 3 cycles.
  - Required: pc held; in HOLD; after stall drops, pc=0x0FF0 once, then 0x0FF4.
- Simultaneous redirects:
  - Stimulus: jump_reg=1 (0x2000), jump=1 and branch_taken=1 in the same cycle.
  - Required: pc=0x2000.
- Misaligned jump register:
  - Stimulus: jump_reg_addr=0x2002.
  - Required: pc=0x80000180; addr_error high for exactly one cycle.
- Wrap-around and mid-HOLD reset:
  - Stimulus: pc=FFFFFFFC then ack; assert rst while in HOLD.
  - Required: pc becomes 0x00000000; rst then gives pc=BFC00000 immediately, pending is dropped and no redirect_taken pulse occurs.
